// File: rtl/ff_emu_pkg.sv
// Shared types and the per-channel next-state rule for the flip-flop emulator bank.
package ff_emu_pkg;

    typedef enum logic [1:0] {
        FF_D  = 2'b00,
        FF_T  = 2'b01,
        FF_JK = 2'b10,
        FF_SR = 2'b11
    } ff_mode_t;

    typedef struct packed {
        logic q;
        logic invalid;
    } ff_next_t;

    function automatic ff_next_t ff_next(input ff_mode_t mode, input logic q,
                                         input logic a, input logic b);
        ff_next_t r;
        r.q       = q;
        r.invalid = 1'b0;
        case (mode)
            FF_D:    r.q = a;
            FF_T:    r.q = q ^ a;
            FF_JK: begin
                case ({a, b})
                    2'b01:   r.q = 1'b0;
                    2'b10:   r.q = 1'b1;
                    2'b11:   r.q = ~q;
                    default: r.q = q;
                endcase
            end
            default: begin
                case ({a, b})
                    2'b01:   r.q = 1'b0;
                    2'b10:   r.q = 1'b1;
                    2'b11:   r.invalid = 1'b1;
                    default: r.q = q;
                endcase
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/slow_tick_gen.sv
// Human-visible slow clock: counts DIV system cycles per half period, pausable by hold.
module slow_tick_gen #(
    parameter int DIV = 20000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic tick,
    output logic slow_clk
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          slow_clk_q, slow_clk_d;
    logic          at_max;

    always_comb begin
        at_max     = (cnt_q == CNT_MAX);
        tick       = rst_n & ~hold & at_max;
        cnt_d      = cnt_q;
        slow_clk_d = slow_clk_q;
        if (!hold) begin
            cnt_d = at_max ? '0 : cnt_q + CW'(1);
        end
        if (tick) begin
            slow_clk_d = ~slow_clk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            slow_clk_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            slow_clk_q <= slow_clk_d;
        end
    end

    assign slow_clk = slow_clk_q;

endmodule

// File: rtl/ff_emulator_bank.sv
// Bank of run-time selectable D/T/JK/SR flip-flops, all updated on the slow clock rising edge.
module ff_emulator_bank
    import ff_emu_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DIV         = 20000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] in_a,
    input  logic [CHANNELS-1:0] in_b,
    input  logic                hold,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] q_n,
    output logic                slow_clk,
    output logic                tick,
    output logic [CHANNELS-1:0] sr_invalid
);
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] b_sync_q, b_sync_d;
    logic [SYNC_STAGES-1:0][1:0]          mode_sync_q, mode_sync_d;
    logic [CHANNELS-1:0]                  a_s, b_s;
    ff_mode_t                             mode_s;
    logic                                 update;

    slow_tick_gen #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .tick     (tick),
        .slow_clk (slow_clk)
    );

    always_comb begin
        a_sync_d    = {a_sync_q[SYNC_STAGES-2:0], in_a};
        b_sync_d    = {b_sync_q[SYNC_STAGES-2:0], in_b};
        mode_sync_d = {mode_sync_q[SYNC_STAGES-2:0], mode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q    <= '0;
            b_sync_q    <= '0;
            mode_sync_q <= '0;
        end else begin
            a_sync_q    <= a_sync_d;
            b_sync_q    <= b_sync_d;
            mode_sync_q <= mode_sync_d;
        end
    end

    assign a_s    = a_sync_q[SYNC_STAGES-1];
    assign b_s    = b_sync_q[SYNC_STAGES-1];
    assign mode_s = ff_mode_t'(mode_sync_q[SYNC_STAGES-1]);
    // Only the tick that raises slow_clk updates state.
    assign update = tick & ~slow_clk;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ff_next_t nxt;
        logic     q_q, q_d;
        logic     inv_q, inv_d;

        always_comb begin
            nxt   = ff_next(mode_s, q_q, a_s[i], b_s[i]);
            q_d   = update ? nxt.q : q_q;
            inv_d = update ? nxt.invalid : inv_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_q   <= 1'b0;
                inv_q <= 1'b0;
            end else begin
                q_q   <= q_d;
                inv_q <= inv_d;
            end
        end

        assign q[i]          = q_q;
        assign sr_invalid[i] = inv_q;
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_ff_emulator_bank.sv
// Randomised bench for ff_emulator_bank against a cycle-count reference model.
module tb_ff_emulator_bank;
    localparam int CH  = 4;
    localparam int DIV = 4;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = '0;
    logic [CH-1:0] in_a = '0, in_b = '0;
    logic          hold = 1'b0;
    logic [CH-1:0] q, q_n, sr_invalid;
    logic          slow_clk, tick;

    int vectors = 0;
    int miscompares = 0;

    int           m_cnt;
    bit           m_slow;
    bit [CH-1:0]  m_q, m_inv;
    bit [CH-1:0]  h_a [SS];
    bit [CH-1:0]  h_b [SS];
    bit [1:0]     h_m [SS];

    ff_emulator_bank #(.CHANNELS(CH), .DIV(DIV), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_a       (in_a),
        .in_b       (in_b),
        .hold       (hold),
        .q          (q),
        .q_n        (q_n),
        .slow_clk   (slow_clk),
        .tick       (tick),
        .sr_invalid (sr_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_slow = 1'b0;
        m_q    = '0;
        m_inv  = '0;
        for (int i = 0; i < SS; i++) begin
            h_a[i] = '0;
            h_b[i] = '0;
            h_m[i] = '0;
        end
    endtask

    task automatic check_outputs(input bit t_exp);
        bit [CH-1:0] nq;
        nq = ~m_q;
        chk("q", 32'(q), 32'(m_q));
        chk("q_n", 32'(q_n), 32'(nq));
        chk("slow_clk", 32'(slow_clk), 32'(m_slow));
        chk("tick", 32'(tick), 32'(t_exp));
        chk("sr_invalid", 32'(sr_invalid), 32'(m_inv));
    endtask

    // One system cycle: drive pins at negedge, compare, then step the model across the next posedge.
    task automatic cycle(input bit [CH-1:0] a, input bit [CH-1:0] b,
                         input bit [1:0] md, input bit hd, input bit r);
        bit          t_exp;
        bit [CH-1:0] sa, sb;
        bit [1:0]    sm;
        @(negedge clk);
        in_a = a; in_b = b; mode = md; hold = hd; rst_n = r;
        #1;
        if (!r) model_reset();
        t_exp = r && !hd && (m_cnt == DIV - 1);
        check_outputs(t_exp);
        if (r) begin
            sa = h_a[SS-1]; sb = h_b[SS-1]; sm = h_m[SS-1];
            if (t_exp && !m_slow) begin
                for (int c = 0; c < CH; c++) begin
                    m_inv[c] = 1'b0;
                    case (sm)
                        2'd0: m_q[c] = sa[c];
                        2'd1: m_q[c] = m_q[c] ^ sa[c];
                        2'd2: m_q[c] = (sa[c] && sb[c]) ? !m_q[c] : sa[c] ? 1'b1 : sb[c] ? 1'b0 : m_q[c];
                        default: begin
                            if (sa[c] && sb[c]) m_inv[c] = 1'b1;
                            else m_q[c] = sa[c] ? 1'b1 : sb[c] ? 1'b0 : m_q[c];
                        end
                    endcase
                end
            end
            if (t_exp) m_slow = !m_slow;
            if (!hd) m_cnt = (m_cnt + 1) % DIV;
            for (int i = SS - 1; i > 0; i--) begin
                h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1]; h_m[i] = h_m[i-1];
            end
            h_a[0] = a; h_b[0] = b; h_m[0] = md;
        end
    endtask

    task automatic run(input int n, input bit [CH-1:0] a, input bit [CH-1:0] b, input bit [1:0] md);
        for (int i = 0; i < n; i++) cycle(a, b, md, 1'b0, 1'b1);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0);
        cycle(in_a, in_b, mode, 1'b0, 1'b0);
        cycle(in_a, in_b, mode, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) cycle('0, '0, 2'd0, 1'b0, 1'b0);
        run(40, 4'b0000, 4'b0000, 2'd0);

        run(7, 4'b1010, 4'b0000, 2'd0);
        run(3, 4'b0101, 4'b0000, 2'd0);
        run(8, 4'b0101, 4'b0000, 2'd0);
        run(24, 4'b0011, 4'b0000, 2'd1);
        run(16, 4'b0101, 4'b0000, 2'd0);
        run(16, 4'b1100, 4'b1010, 2'd2);
        run(16, 4'b1001, 4'b0000, 2'd0);
        run(16, 4'b1111, 4'b1111, 2'd3);
        run(16, 4'b0000, 4'b0000, 2'd3);

        run(2, 4'b0110, 4'b1001, 2'd1);
        for (int i = 0; i < 20; i++) cycle(4'b1111, 4'b0000, 2'd1, 1'b1, 1'b1);
        run(5, 4'b1111, 4'b0000, 2'd1);
        reset_mid();
        run(12, 4'b0110, 4'b0000, 2'd0);

        begin
            bit [CH-1:0] ra, rb;
            bit [1:0]    rm;
            ra = '0; rb = '0; rm = '0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    ra = CH'($urandom);
                    rb = CH'($urandom);
                end
                if ($urandom_range(0, 15) == 0) rm = 2'($urandom);
                cycle(ra, rb, rm, ($urandom_range(0, 7) == 0), 1'b1);
                if (i == 250) reset_mid();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
